// File: rtl/mul_result_capture.sv
// mul_result_capture: latches shift-add multiplier partial products, counts steps, hands off the final product over valid/ready
// clk/rst: clock and async active-high reset; start: begin a new product; in/done: datapath partial product and completion flag
// answer/step_cnt: captured product and step count; busy: capturing; valid/ready: output handshake; err: sticky step timeout
module mul_result_capture #(
  parameter int WIDTH = 16,
  parameter int STEPS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic             done,
  input  logic             ready,
  output logic [WIDTH-1:0] answer,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             valid,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] answer_q, answer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, busy_q, valid_q;
  always_comb begin
    state_d = state_q;
    answer_d = answer_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        cnt_d = '0;
        err_d = 1'b0;
      end
      CAPTURE: if (done) begin
        answer_d = in;
        state_d = HOLD;
      end else if (cnt_q < CNT_W'(STEPS)) begin
        answer_d = in;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      HOLD: if (ready) begin
        state_d = start ? CAPTURE : IDLE;
        cnt_d = start ? '0 : cnt_q;
        err_d = start ? 1'b0 : err_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      answer_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      answer_q <= answer_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      busy_q <= state_d == CAPTURE;
      valid_q <= state_d == HOLD;
    end
  end
  assign answer = answer_q;
  assign step_cnt = cnt_q;
  assign busy = busy_q;
  assign valid = valid_q;
  assign err = err_q;
endmodule

// File: doc/mul_result_capture.md
Name: mul_result_capture

Overview:
- Parametrised result-capture stage for the iterative shift-add multiplier datapath; successor to the fixed 16-bit capture register.
- Tracks partial products each step and counts steps, with a per-operation start.
- Latches the final product and presents it downstream over a valid/ready handshake.
- Flags a step-count timeout when the datapath never asserts done.

Parameters:
- WIDTH, 16, product width in bits (2*N for an NxN multiplier).
- STEPS, 8, maximum datapath steps per product before timeout (N for NxN).
- CNT_W, 4, step counter width; must satisfy 2**CNT_W > STEPS.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, single-cycle request to begin capturing a new product.
- in, input, WIDTH, running partial product from the datapath.
- done, input, 1, datapath flag: product complete, `in` is final this cycle.
- answer, output, WIDTH, captured product (registered).
- step_cnt, output, CNT_W, steps captured in the current or last operation.
- busy, output, 1, high while in CAPTURE.
- valid, output, 1, answer holds a final product awaiting acceptance.
- ready, input, 1, downstream accepts answer when valid&ready.
- err, output, 1, sticky timeout flag.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, answer=0, step_cnt=0, busy=0, valid=0, err=0. Reset mid-operation aborts with no further output.
- States: IDLE, CAPTURE, HOLD. busy=1 only in CAPTURE; valid=1 only in HOLD. Both are registered and change on the transition edge.
- IDLE:
  - start=1 -> CAPTURE; step_cnt<=0; err<=0. answer keeps its old value.
  - start=0 -> remain in IDLE; all outputs held.
- CAPTURE, each edge:
  - done=0 and step_cnt<STEPS: answer<=in; step_cnt<=step_cnt+1.
  - done=1: answer<=in (final value latched on the done cycle); step_cnt unchanged; -> HOLD. Latency from done to valid=1 is 1 cycle.
  - done=0 and step_cnt==STEPS: timeout. err<=1; answer unchanged; -> IDLE; valid stays 0.
  - start is ignored in CAPTURE.
- HOLD:
  - answer, step_cnt and valid are held stable until ready=1.
  - ready=1 and start=0 -> IDLE; valid<=0.
  - ready=1 and start=1 in the same cycle -> CAPTURE directly. valid<=0, step_cnt<=0, err<=0. No idle bubble.
  - start with ready=0 is ignored; the product is not overwritten.
- Arithmetic:
  - step_cnt is an unsigned increment, never exceeds STEPS, and never wraps.
  - answer is a straight copy of in, with no truncation or extension.
- err stays set through IDLE and is cleared only by an accepted start or by reset.
- done and ready are sampled only in CAPTURE and HOLD respectively; they are don't-care elsewhere.

Test Plan:
- Reset then idle: assert rst mid-clock -> all outputs 0 immediately (asynchronous). With start=0 for 5 cycles, nothing changes.
- Normal 8x8 run (WIDTH=16, STEPS=8): pulse start, then 7 cycles done=0 with in=0x0001..0x0007, then done=1 with in=0x3C21. Expect:
  - answer=0x3C21, valid=1 and step_cnt=7 one cycle after done.
  - busy=1 exactly 8 cycles.
  - ready=1 -> valid=0 next cycle.
- Backpressure: hold ready=0 for 10 cycles in HOLD while toggling start and changing in -> answer, valid and step_cnt unchanged. Then ready=1 -> IDLE.
- Back-to-back: in HOLD assert ready=1 and start=1 together -> next cycle busy=1, valid=0, step_cnt=0. The second product 0x00FF completes normally.
- Timeout: start, keep done=0 for 9 cycles -> after step_cnt reaches 8, err=1, state IDLE, valid=0, answer=last in. A following start clears err.
- Reset mid-capture: assert rst at step 4 -> answer=0, busy=0, step_cnt=0 immediately. After release, start runs a clean capture.
